// File: rtl/rv32i_muldiv_unit_if.sv
// rtl/rv32i_muldiv_unit_if.sv - core-side handshake and operand bus for the RV32M multiply/divide unit
interface rv32i_muldiv_unit_if;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_addr;
    logic        rd_we;

    // Core / pipeline side: launches ops and consumes the writeback
    modport master (
        output start, flush, funct3, rs1_data, rs2_data, rd_addr_in,
        input  busy, done, result, rd_addr, rd_we
    );

    // Execute-unit side
    modport slave (
        input  start, flush, funct3, rs1_data, rs2_data, rd_addr_in,
        output busy, done, result, rd_addr, rd_we
    );
endinterface

// File: rtl/rv32i_muldiv_unit.sv
// rtl/rv32i_muldiv_unit.sv - iterative RV32M multiply/divide execute unit with sign fixup
module rv32i_muldiv_unit #(
    parameter int XLEN          = 32,
    parameter bit EARLY_SPECIAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32i_muldiv_unit_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          r_state;
    logic [4:0]          r_cnt;
    logic [2:0]          r_funct3;
    logic [4:0]          r_rd_addr;
    logic [XLEN-1:0]     r_opnd;     // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0]   r_acc;      // mul: {hi, lo/multiplier}; div: {remainder, quotient/dividend}
    logic                r_neg_q;    // product or quotient must be negated
    logic                r_neg_r;    // remainder must be negated (dividend was negative)
    logic [XLEN-1:0]     r_result;

    // ---- operand decode at the start edge ----
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_is_div   = bus.funct3[2];
    // MUL/MULH/MULHSU: A signed; DIV/REM: A signed; only the U forms are unsigned
    assign w_a_signed = w_is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    // B is signed only for MUL/MULH and DIV/REM
    assign w_b_signed = w_is_div ? ~bus.funct3[0] : ~bus.funct3[1];
    assign w_a_neg    = w_a_signed & bus.rs1_data[XLEN-1];
    assign w_b_neg    = w_b_signed & bus.rs2_data[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~bus.rs1_data + 1'b1) : bus.rs1_data;
    assign w_b_mag    = w_b_neg ? (~bus.rs2_data + 1'b1) : bus.rs2_data;
    assign w_b_zero   = (bus.rs2_data == '0);
    assign w_ovf      = w_is_div & ~bus.funct3[0]
                      & (bus.rs1_data == 32'h8000_0000) & (bus.rs2_data == 32'hFFFF_FFFF);
    assign w_special  = EARLY_SPECIAL & w_is_div & (w_b_zero | w_ovf);
    assign w_special_res = w_b_zero ? (bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF)
                                    : (bus.funct3[1] ? 32'h0000_0000 : 32'h8000_0000);

    // ---- one shift-add multiply step ----
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_next;

    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // ---- one restoring-division step ----
    logic [XLEN:0]     w_trial;
    logic [XLEN+1:0]   w_diff;
    logic              w_fits;
    logic [XLEN-1:0]   w_rem_next;
    logic [2*XLEN-1:0] w_div_next;
    logic              w_unused_bits;

    assign w_trial    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff     = {1'b0, w_trial} - {2'b00, r_opnd};
    assign w_fits     = ~w_diff[XLEN+1];
    assign w_rem_next = w_fits ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
    assign w_div_next = {w_rem_next, r_acc[XLEN-2:0], w_fits};
    // A fitting difference and a non-fitting trial are both below the divisor
    assign w_unused_bits = w_diff[XLEN] ^ w_trial[XLEN];

    // ---- sign fixup and result select ----
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

    // Pick low/high product half, quotient or remainder from the captured funct3
    always_comb begin
        w_fix_res = w_prod[XLEN-1:0];
        case (r_funct3)
            3'b000:                 w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_rem;
        endcase
    end

    // Control FSM plus datapath registers; flush overrides everything but reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_rd_addr <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_funct3  <= bus.funct3;
                        r_rd_addr <= bus.rd_addr_in;
                        r_cnt     <= 5'd31;
                        r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
                        r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        // Divide-by-zero keeps an all-ones quotient positive on the slow path
                        r_neg_q   <= (w_a_neg ^ w_b_neg) & ~(w_is_div & w_b_zero);
                        r_neg_r   <= w_a_neg;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.result  = r_result;
    assign bus.rd_addr = r_rd_addr;
    assign bus.rd_we   = (r_state == S_DONE) & (r_rd_addr != 5'd0);

endmodule

// File: tb/tb_rv32i_muldiv_unit.sv
// tb/tb_rv32i_muldiv_unit.sv - directed self-checking bench for rv32i_muldiv_unit
module tb_rv32i_muldiv_unit;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    rv32i_muldiv_unit_if bus ();

    rv32i_muldiv_unit #(.XLEN(32), .EARLY_SPECIAL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Launch one op, optionally re-pulse start at sample inj, then check latency and writeback
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_lat, input int inj);
        int lat;
        bit seen;
        @(negedge clk);
        bus.funct3     = f3;
        bus.rs1_data   = a;
        bus.rs2_data   = b;
        bus.rd_addr_in = rd;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 40) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (lat == inj) begin
                    bus.start    = 1'b1;
                    bus.funct3   = 3'b000;
                    bus.rs1_data = 32'h3;
                    bus.rs2_data = 32'h4;
                end
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                lat++;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, {32'h0, bus.result}, {32'h0, exp});
        check({tag, "_rd_addr"}, {59'h0, bus.rd_addr}, {59'h0, rd});
        check({tag, "_rd_we"}, {63'h0, bus.rd_we}, {63'h0, (rd != 5'd0)});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {63'h0, bus.done}, 64'h0);
        check({tag, "_idle"}, {63'h0, bus.busy}, 64'h0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        n_total        = 0;
        n_pass         = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.flush      = 1'b0;
        bus.funct3     = 3'b000;
        bus.rs1_data   = 32'h0;
        bus.rs2_data   = 32'h0;
        bus.rd_addr_in = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'h0, bus.busy}, 64'h0);
        check("reset_done", {63'h0, bus.done}, 64'h0);
        check("reset_rd_we", {63'h0, bus.rd_we}, 64'h0);
        check("reset_result", {32'h0, bus.result}, 64'h0);
        check("reset_rd_addr", {59'h0, bus.rd_addr}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Multiplies
        run_op("mul_7_m3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34, 0);
        run_op("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 34, 0);
        run_op("mulhu_max_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 34, 0);
        run_op("mulhsu_m1_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 34, 0);

        // Divides
        run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD, 34, 0);
        run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 34, 0);
        run_op("divu_100_7",    3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        34, 0);
        run_op("remu_100_7",    3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         34, 0);

        // Early special cases
        run_op("div_5_0",       3'b100, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1, 0);
        run_op("remu_5_0",      3'b111, 32'd5,         32'd0,         5'd14, 32'd5,         1, 0);
        run_op("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1, 0);
        run_op("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0,         1, 0);

        // start while busy is ignored
        run_op("divu_restart",  3'b101, 32'd100,       32'd7,         5'd17, 32'd14,        34, 5);

        // flush mid-CALC: no done, result unchanged
        @(negedge clk);
        bus.funct3     = 3'b000;
        bus.rs1_data   = 32'd3;
        bus.rs2_data   = 32'd5;
        bus.rd_addr_in = 5'd18;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", {63'h0, bus.busy}, 64'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.rd_we) seen = 1'b1;
        end
        check("flush_no_done", {63'h0, seen}, 64'h0);
        check("flush_result_kept", {32'h0, bus.result}, {32'h0, 32'd14});

        run_op("mul_3_4",       3'b000, 32'd3,         32'd4,         5'd19, 32'd12,        34, 0);

        // flush and start together in IDLE: flush wins
        @(negedge clk);
        bus.funct3 = 3'b000;
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_idle", {63'h0, bus.busy}, 64'h0);

        // async reset mid-CALC
        @(negedge clk);
        bus.funct3     = 3'b101;
        bus.rs1_data   = 32'd100;
        bus.rs2_data   = 32'd7;
        bus.rd_addr_in = 5'd20;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("pre_rst_busy", {63'h0, bus.busy}, 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", {63'h0, bus.busy}, 64'h0);
        check("async_rst_done", {63'h0, bus.done}, 64'h0);
        check("async_rst_rd_we", {63'h0, bus.rd_we}, 64'h0);
        check("async_rst_result", {32'h0, bus.result}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // rd = x0: done pulses but no register write
        run_op("divu_rd0",      3'b101, 32'd100,       32'd7,         5'd0,  32'd14,        34, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
